// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is
// resolved per stage, with a valid/ready handshake on both sides.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int GSAFE = (GROUP < 1) ? 1 : GROUP;
    localparam int NG    = WIDTH / GSAFE;

    if (GROUP < 1 || (WIDTH % GSAFE) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    // Stage k holds: operands (k < NG), resolved low sum bits, carry into group k.
    logic [WIDTH-1:0] a_q [NG];
    logic [WIDTH-1:0] b_q [NG];
    logic [WIDTH-1:0] s_q [NG+1];
    logic [NG:0]      c_q;
    logic [NG:0]      v_q;
    logic             ovf_q;

    logic [GROUP:0]   grp_c [NG];
    logic [GROUP-1:0] grp_s [NG];
    logic             adv;

    function automatic logic [GROUP:0] group_carries(
        input logic [WIDTH-1:0] va,
        input logic [WIDTH-1:0] vb,
        input int               lo,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        g    = va[lo +: GROUP] & vb[lo +: GROUP];
        p    = va[lo +: GROUP] ^ vb[lo +: GROUP];
        c    = '0;
        c[0] = ci;
        // Each carry is a flat sum of generate terms gated by propagate products.
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i];
            t      = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (t & g[j]);
                t      = t & p[j];
            end
            c[i+1] = c[i+1] | (t & ci);
        end
        return c;
    endfunction

    always_comb begin
        for (int k = 0; k < NG; k++) begin
            grp_c[k] = group_carries(a_q[k], b_q[k], k * GROUP, c_q[k]);
            grp_s[k] = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP]
                       ^ grp_c[k][GROUP-1:0];
        end
    end

    // Handshake: a beat moves on a rising edge when valid & ready are both high.
    // The whole pipe advances together whenever the output slot is empty or is
    // being drained, so in_ready depends combinationally on out_ready.
    assign adv       = ~v_q[NG] | out_ready;
    assign in_ready  = adv & rst;
    assign out_valid = v_q[NG];
    assign sum       = s_q[NG];
    assign cout      = c_q[NG];
    assign ovf       = ovf_q;
    assign busy      = |v_q;

    // Data registers only load behind a valid beat, so outputs stay 0 until
    // the first real result arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k <= NG; k++) begin
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                a_q[0] <= a;
                b_q[0] <= sub ? ~b : b;
                c_q[0] <= sub | cin;
            end
            for (int k = 1; k < NG; k++) begin
                if (v_q[k-1]) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                end
            end
            for (int k = 1; k <= NG; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    s_q[k]                      <= s_q[k-1];
                    s_q[k][(k-1)*GROUP +: GROUP] <= grp_s[k-1];
                    c_q[k]                      <= grp_c[k-1][GROUP];
                end
            end
            if (v_q[NG-1]) begin
                ovf_q <= grp_c[NG-1][GROUP] ^ grp_c[NG-1][GROUP-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (16/4): directed vectors, stall, mid-flight
// reset and a randomised handshake stream checked by a queue scoreboard.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    bit lat_mode = 1'b0;
    bit held = 1'b0;
    logic [W+1:0] held_val;
    logic [W+1:0] exp_q[$];
    int           acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         v;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
        v    = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    // Monitor: stall checks while held, pop-and-compare on each transfer.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (!out_ready) begin
                chk("in_ready_stall", {31'b0, in_ready}, 32'd0);
                if (held) chk("hold_stable", {14'b0, cout, ovf, sum}, {14'b0, held_val});
                held     = 1'b1;
                held_val = {cout, ovf, sum};
            end else begin
                held = 1'b0;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {14'b0, cout, ovf, sum}, 32'hDEAD);
                end else begin
                    chk("result", {14'b0, cout, ovf, sum}, {14'b0, exp_q.pop_front()});
                    if (lat_mode) chk("latency", cyc - acc_q[0], NG);
                    void'(acc_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, input logic [W+1:0] te);
        int  n;
        bit  done;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(te);
                acc_q.push_back(cyc + 1);
                @(posedge clk);
                #1;
                done = 1'b1;
            end else if (n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        ra = W'($urandom_range(0, 65535));
        rb = W'($urandom_range(0, 65535));
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    bit stream_done;
    int base_cnt;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_outputs", {14'b0, cout, ovf, sum}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Directed vectors, expected {cout, ovf, sum} worked by hand.
        lat_mode = 1'b1;
        send(16'h000A, 16'h0005, 1'b0, 1'b0, {1'b0, 1'b0, 16'h000F});
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        send(16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send(16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF});
        send(16'h0000, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0001});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        send(16'h1234, 16'h1234, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
        send(16'h00F0, 16'h0F10, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});
        drain();
        lat_mode = 1'b0;

        // Back-to-back stream with a 3-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) rand_beat();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three beats in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333});
        send(16'h4444, 16'h1111, 1'b0, 1'b1, {1'b1, 1'b0, 16'h3333});
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_outputs", {14'b0, cout, ovf, sum}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        base_cnt = out_cnt;
        lat_mode = 1'b1;
        send(16'h0102, 16'h0304, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0407});
        drain();
        repeat (8) @(posedge clk);
        chk("post_rst_beats", out_cnt - base_cnt, 32'd1);
        lat_mode = 1'b0;

        // Random in_valid gaps and random out_ready.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                    rand_beat();
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
